// File: rtl/tcp_encoder.sv
// -----------------------------------------------------------------------------
// tcp_encoder
//
// Transmit-side TCP segment builder. On an accepted `start` it latches the TCP
// header fields and the IP pseudo-header information. It then takes the
// payload as 32-bit big-endian words into an internal buffer while it sums the
// one's-complement checksum. Last, it emits the segment on a 32-bit word bus:
// five header words (six with the MSS option), then the payload, with the last
// word zero-padded.
//
// Optional build macro: TCP_MSS_OPTION_EN
//   When it is defined, ports mss_en/mss are added. With mss_en=1 the segment
//   carries a 4-byte MSS option word after W4, and the data offset becomes 6.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   src_ip, dest_ip       pseudo-header addresses            (sampled on start)
//   src_port, dest_port   TCP ports                          (sampled on start)
//   seq_num, ack_num      sequence / acknowledgement numbers (sampled on start)
//   f_urg..f_fin          control flags                      (sampled on start)
//   window, urg_ptr       window size, urgent pointer        (sampled on start)
//   len_data              payload byte count                 (sampled on start)
//   mss_en, mss           MSS option enable / value          (macro builds only)
//   start                 one-cycle request, ignored while busy
//   data_in/_valid        payload words, byte 0 in [31:24]
//   busy                  segment in progress
//   data/data_valid       segment word stream (never stalls)
//   len_tcp               header + payload length in bytes
//   fin                   pulse on the final segment word
//   err                   pulse: request rejected (payload too long)
//
// Handshake: data_in is consumed on every cycle where data_in_valid=1 and the
// encoder is in LOAD. data_in_valid in any other cycle is dropped. The output
// has no ready: every cycle with data_valid=1 carries one word, and the words
// of a segment come in consecutive cycles.
// -----------------------------------------------------------------------------
module tcp_encoder #(
  parameter int MAX_WORDS = 16,
  parameter int AW        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] src_ip,
  input  logic [31:0] dest_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dest_port,
  input  logic [31:0] seq_num,
  input  logic [31:0] ack_num,
  input  logic        f_urg,
  input  logic        f_ack,
  input  logic        f_psh,
  input  logic        f_rst,
  input  logic        f_syn,
  input  logic        f_fin,
  input  logic [15:0] window,
  input  logic [15:0] urg_ptr,
  input  logic [15:0] len_data,
`ifdef TCP_MSS_OPTION_EN
  input  logic        mss_en,
  input  logic [15:0] mss,
`endif
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic        data_in_valid,
  output logic        busy,
  output logic [31:0] data,
  output logic        data_valid,
  output logic [15:0] len_tcp,
  output logic        fin,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FOLD,
    S_HDR,
    S_PAY,
    S_DONE
  } state_t;

  // The accumulator never folds while it sums, so it is sized for the worst
  // case: 17 header/pseudo-header terms plus 2 per payload word, each up to
  // 0xFFFF. That stays below 2**24 for the default buffer depth.
  localparam int          ACC_W     = 24;
  localparam logic [16:0] MAX_BYTES = 17'(4 * MAX_WORDS);
  localparam logic [AW:0] ONE       = (AW + 1)'(1);

  function automatic logic [ACC_W-1:0] ext16(input logic [15:0] v);
    return {{(ACC_W - 16){1'b0}}, v};
  endfunction

  state_t state, state_next;

  // Latched segment context
  logic [15:0]      src_port_q, dest_port_q;
  logic [31:0]      seq_q, ack_q;
  logic [15:0]      off_flags_q;   // upper half of W3: data offset + flags
  logic [15:0]      window_q, urg_ptr_q, mss_q;
  logic             opt_q;
  logic [1:0]       len_rem_q;     // len_data mod 4, selects the tail mask
  logic [AW:0]      nwords_q;
  logic [15:0]      csum_q;
  logic [ACC_W-1:0] acc_q;
  logic [AW:0]      cnt_q;         // LOAD write index, then PAY read index
  logic [2:0]       hcnt_q;        // header word index in HDR
  logic [31:0]      buf_mem [MAX_WORDS];

  // Request decode
  logic             opt_in;
  logic [15:0]      mss_in;
  logic             too_long;
  logic [16:0]      len_plus3;
  logic [AW:0]      nwords_in;
  logic [15:0]      len_tcp_in;
  logic [15:0]      off_flags_in;
  logic [ACC_W-1:0] seed;

`ifdef TCP_MSS_OPTION_EN
  assign opt_in = mss_en;
  assign mss_in = mss;
`else
  assign opt_in = 1'b0;
  assign mss_in = 16'd0;
`endif

  assign too_long  = {1'b0, len_data} > MAX_BYTES;
  assign len_plus3 = {1'b0, len_data} + 17'd3;
  // ceil(len_data/4). This is only used when len_data <= 4*MAX_WORDS, so the
  // result fits in AW+1 bits.
  assign nwords_in    = len_plus3[AW+2:2];
  assign len_tcp_in   = len_data + (opt_in ? 16'd24 : 16'd20);
  assign off_flags_in = {(opt_in ? 4'd6 : 4'd5), 6'd0,
                         f_urg, f_ack, f_psh, f_rst, f_syn, f_fin};

  // Pseudo-header + header sum, with the checksum field counted as zero.
  assign seed = ext16(src_ip[31:16])  + ext16(src_ip[15:0])
              + ext16(dest_ip[31:16]) + ext16(dest_ip[15:0])
              + ext16(16'h0006)       + ext16(len_tcp_in)
              + ext16(src_port)       + ext16(dest_port)
              + ext16(seq_num[31:16]) + ext16(seq_num[15:0])
              + ext16(ack_num[31:16]) + ext16(ack_num[15:0])
              + ext16(off_flags_in)   + ext16(window)
              + ext16(urg_ptr)
              + (opt_in ? (ext16(16'h0204) + ext16(mss_in)) : '0);

  // Index of the last payload word. LOAD uses it for the write side and PAY
  // uses it for the read side.
  logic cnt_last;
  assign cnt_last = (cnt_q == (nwords_q - ONE));

  // Bytes past len_data in the final word are cleared before they are stored
  // and before they are summed, so the padding goes out as zeros.
  logic [31:0] load_word;
  always_comb begin
    load_word = data_in;
    if (cnt_last) begin
      case (len_rem_q)
        2'd1:    load_word = {data_in[31:24], 24'd0};
        2'd2:    load_word = {data_in[31:16], 16'd0};
        2'd3:    load_word = {data_in[31:8],  8'd0};
        default: load_word = data_in;
      endcase
    end
  end

  // Two end-around-carry folds. After the first fold the value is at most
  // 0xFFFF + 0xFF, so the second fold cannot carry out of 16 bits.
  logic [ACC_W-1:0] fold1;
  logic [15:0]      fold2;
  assign fold1 = ext16(acc_q[15:0]) + {{(ACC_W - 8){1'b0}}, acc_q[23:16]};
  assign fold2 = fold1[15:0] + {8'd0, fold1[23:16]};

  logic [2:0] hdr_last;
  assign hdr_last = opt_q ? 3'd5 : 3'd4;

  logic [31:0] hdr_word;
  always_comb begin
    hdr_word = '0;
    case (hcnt_q)
      3'd0:    hdr_word = {src_port_q, dest_port_q};
      3'd1:    hdr_word = seq_q;
      3'd2:    hdr_word = ack_q;
      3'd3:    hdr_word = {off_flags_q, window_q};
      3'd4:    hdr_word = {csum_q, urg_ptr_q};
      3'd5:    hdr_word = {8'h02, 8'h04, mss_q};
      default: hdr_word = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and stream outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    data_valid = 1'b0;
    data       = '0;
    fin        = 1'b0;
    case (state)
      // DONE has busy=0, so a new request is taken there exactly as in IDLE.
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (start && !too_long) begin
          if (len_data == 16'd0) state_next = S_FOLD;
          else                   state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        busy = 1'b1;
        if (data_in_valid && cnt_last) state_next = S_FOLD;
      end
      S_FOLD: begin
        busy       = 1'b1;
        state_next = S_HDR;
      end
      S_HDR: begin
        busy       = 1'b1;
        data_valid = 1'b1;
        data       = hdr_word;
        if (hcnt_q == hdr_last) begin
          if (nwords_q == '0) begin
            fin        = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_PAY;
          end
        end
      end
      S_PAY: begin
        busy       = 1'b1;
        data_valid = 1'b1;
        data       = buf_mem[cnt_q[AW-1:0]];
        if (cnt_last) begin
          fin        = 1'b1;
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: context latch, checksum accumulation, counters, err pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      err         <= 1'b0;
      len_tcp     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      csum_q      <= '0;
      nwords_q    <= '0;
      len_rem_q   <= '0;
      opt_q       <= 1'b0;
      mss_q       <= '0;
      src_port_q  <= '0;
      dest_port_q <= '0;
      seq_q       <= '0;
      ack_q       <= '0;
      off_flags_q <= '0;
      window_q    <= '0;
      urg_ptr_q   <= '0;
    end else begin
      err <= start && too_long && (state == S_IDLE || state == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !too_long) begin
            len_tcp     <= len_tcp_in;
            acc_q       <= seed;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            nwords_q    <= nwords_in;
            len_rem_q   <= len_data[1:0];
            opt_q       <= opt_in;
            mss_q       <= mss_in;
            src_port_q  <= src_port;
            dest_port_q <= dest_port;
            seq_q       <= seq_num;
            ack_q       <= ack_num;
            off_flags_q <= off_flags_in;
            window_q    <= window;
            urg_ptr_q   <= urg_ptr;
          end
        end
        S_LOAD: begin
          if (data_in_valid) begin
            acc_q <= acc_q + ext16(load_word[31:16]) + ext16(load_word[15:0]);
            cnt_q <= cnt_q + ONE;
          end
        end
        S_FOLD: begin
          csum_q <= ~fold2;
          cnt_q  <= '0;
          hcnt_q <= '0;
        end
        S_HDR: hcnt_q <= hcnt_q + 3'd1;
        S_PAY: cnt_q  <= cnt_q + ONE;
        default: ;
      endcase
    end
  end

  // Payload buffer. There is no reset: its contents are only read back after
  // they have been written for the current segment.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && data_in_valid) buf_mem[cnt_q[AW-1:0]] <= load_word;
  end

endmodule

// File: tb/tb_tcp_encoder.sv
// -----------------------------------------------------------------------------
// tb_tcp_encoder: self-checking bench for tcp_encoder. The reference model
// builds each expected segment from the field values and payload bytes with
// plain arithmetic: header words plus an RFC-style one's-complement sum over
// 16-bit words.
// -----------------------------------------------------------------------------
module tb_tcp_encoder;
  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_ip, dest_ip, seq_num, ack_num;
  logic [15:0] src_port, dest_port, window, urg_ptr, len_data;
  logic        f_urg, f_ack, f_psh, f_rst, f_syn, f_fin;
  logic        start, data_in_valid;
  logic [31:0] data_in;
  logic        busy, data_valid, fin, err;
  logic [31:0] data;
  logic [15:0] len_tcp;
`ifdef TCP_MSS_OPTION_EN
  logic        mss_en;
  logic [15:0] mss;
`endif

  always #5 clk = ~clk;

  tcp_encoder #(.MAX_WORDS(MW), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .src_ip(src_ip), .dest_ip(dest_ip),
    .src_port(src_port), .dest_port(dest_port),
    .seq_num(seq_num), .ack_num(ack_num),
    .f_urg(f_urg), .f_ack(f_ack), .f_psh(f_psh),
    .f_rst(f_rst), .f_syn(f_syn), .f_fin(f_fin),
    .window(window), .urg_ptr(urg_ptr), .len_data(len_data),
`ifdef TCP_MSS_OPTION_EN
    .mss_en(mss_en), .mss(mss),
`endif
    .start(start), .data_in(data_in), .data_in_valid(data_in_valid),
    .busy(busy), .data(data), .data_valid(data_valid),
    .len_tcp(len_tcp), .fin(fin), .err(err)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  pay_b [0:63];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [15:0] exp_len;

  // Observations collected by run_segment
  int          fin_idx, fin_cnt, err_cnt, err_cyc, dv_cnt, first_dv, last_drive;
  bit          busy_ever, timed_out;
  logic        busy_after_fin;
  logic [15:0] len_seen;

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic clear_fields();
    src_ip = 0; dest_ip = 0; seq_num = 0; ack_num = 0;
    src_port = 0; dest_port = 0; window = 0; urg_ptr = 0; len_data = 0;
    {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin} = 6'b0;
`ifdef TCP_MSS_OPTION_EN
    mss_en = 1'b0; mss = 16'd0;
`endif
  endtask

  task automatic rand_fields(input int max_len);
    src_ip = $urandom; dest_ip = $urandom; seq_num = $urandom; ack_num = $urandom;
    src_port = 16'($urandom); dest_port = 16'($urandom);
    window = 16'($urandom); urg_ptr = 16'($urandom);
    {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin} = 6'($urandom);
    len_data = 16'($urandom_range(0, max_len));
`ifdef TCP_MSS_OPTION_EN
    mss_en = 1'($urandom_range(0, 1)); mss = 16'($urandom);
`endif
    for (int i = 0; i < 64; i++) pay_b[i] = 8'($urandom);
  endtask

  // Reference model: the expected word stream and length from the fields.
  task automatic build_expected();
    int          s;
    logic [15:0] w3hi, csum;
    logic [31:0] w;
    bit          opt = 1'b0;
`ifdef TCP_MSS_OPTION_EN
    opt = mss_en;
    s   = 0;
`endif
    exp_len = len_data + (opt ? 16'd24 : 16'd20);
    w3hi = {(opt ? 4'd6 : 4'd5), 6'd0, f_urg, f_ack, f_psh, f_rst, f_syn, f_fin};
    s = 0;
    s = s + src_ip[31:16] + src_ip[15:0] + dest_ip[31:16] + dest_ip[15:0];
    s = s + 6 + exp_len + src_port + dest_port;
    s = s + seq_num[31:16] + seq_num[15:0] + ack_num[31:16] + ack_num[15:0];
    s = s + w3hi + window + urg_ptr;
`ifdef TCP_MSS_OPTION_EN
    if (opt) s = s + 32'h0204 + mss;
`endif
    for (int i = 0; i < int'(len_data); i += 2)
      s = s + {pay_b[i], ((i + 1 < int'(len_data)) ? pay_b[i+1] : 8'h00)};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    csum = ~s[15:0];
    exp_q.delete();
    exp_q.push_back({src_port, dest_port});
    exp_q.push_back(seq_num);
    exp_q.push_back(ack_num);
    exp_q.push_back({w3hi, window});
    exp_q.push_back({csum, urg_ptr});
`ifdef TCP_MSS_OPTION_EN
    if (opt) exp_q.push_back({8'h02, 8'h04, mss});
`endif
    for (int k = 0; k < (int'(len_data) + 3) / 4; k++) begin
      for (int j = 0; j < 4; j++)
        w[31-8*j -: 8] = (4*k + j < int'(len_data)) ? pay_b[4*k+j] : 8'h00;
      exp_q.push_back(w);
    end
  endtask

  // Starts one segment and feeds n_drive payload words, with random idle gaps
  // up to gap_max. It records the output stream and the control pulses. With
  // disturb=1 it also pulses start and data_in_valid where both must be ignored.
  task automatic run_segment(input int gap_max, input bit disturb, input int n_drive);
    int sent   = 0;
    int fin_at = -1;
    obs_q.delete();
    fin_idx = -1; fin_cnt = 0; err_cnt = 0; err_cyc = -1; dv_cnt = 0;
    busy_after_fin = 1'b1; busy_ever = 1'b0; len_seen = 0;
    first_dv = -1; last_drive = -1; timed_out = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start = 1'b0; data_in_valid = 1'b0; data_in = $urandom;
      if (busy) begin busy_ever = 1'b1; len_seen = len_tcp; end
      if (fin_at >= 0 && cyc == fin_at + 1) busy_after_fin = busy;
      if (data_valid) begin
        dv_cnt++;
        if (first_dv < 0) first_dv = cyc;
        if (fin) fin_idx = obs_q.size();
        obs_q.push_back(data);
      end
      if (fin) begin fin_cnt++; fin_at = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if ((fin_at >= 0 && cyc == fin_at + 1) || (err_cyc >= 0 && cyc >= err_cyc + 3)) begin
        timed_out = 1'b0;
        break;
      end
      if (sent < n_drive && $urandom_range(0, gap_max) == 0) begin
        data_in = {pay_b[4*sent], pay_b[4*sent+1], pay_b[4*sent+2], pay_b[4*sent+3]};
        data_in_valid = 1'b1;
        last_drive = cyc;
        sent++;
      end else if (disturb && sent == n_drive) begin
        data_in_valid = 1'($urandom_range(0, 1));
        if (data_valid && obs_q.size() <= 3) begin start = 1'b1; data_in_valid = 1'b1; end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data_in_valid = 1'b0; data_in = '0;
    clear_fields();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, data_valid, fin, err} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, data_valid, fin, err});
    end
    checks++;
    if (data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", data); end
    checks++;
    if (len_tcp !== 16'd0) begin failures++; $display("FAIL reset_len got=%h exp=0", len_tcp); end
    reset = 1'b0;
  endtask

  task automatic test_zero_len();
    clear_fields();
    exp_q = '{32'h0, 32'h0, 32'h0, 32'h50000000, 32'hAFE50000};
    run_segment(0, 1'b0, 0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL zero_timeout got=1 exp=0"); end
    checks++;
    if (len_seen !== 16'h0014) begin failures++; $display("FAIL zero_len_tcp got=%h exp=0014", len_seen); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL zero_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL zero_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (fin_idx != 4 || fin_cnt != 1) begin failures++; $display("FAIL zero_fin got_idx=%0d cnt=%0d exp_idx=4 cnt=1", fin_idx, fin_cnt); end
    checks++;
    if (busy_after_fin !== 1'b0) begin failures++; $display("FAIL zero_busy_drop got=%b exp=0", busy_after_fin); end
    checks++;
    if (first_dv != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", first_dv); end
  endtask

  task automatic test_hello();
    logic [7:0] msg [0:10];
    msg = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57, 8'h6f, 8'h72, 8'h6c, 8'h64};
    clear_fields();
    src_ip = 32'h9801331b; dest_ip = 32'h980e5e4b;
    src_port = 16'ha08f; dest_port = 16'h2694;
    seq_num = 1; ack_num = 2; window = 3; urg_ptr = 4; len_data = 11;
    {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin} = 6'b111111;
    for (int i = 0; i < 64; i++) pay_b[i] = (i < 11) ? msg[i] : 8'($urandom);
    exp_q = '{32'ha08f2694, 32'h1, 32'h2, 32'h503f0003, 32'hd5280004,
              32'h48656c6c, 32'h6f20576f, 32'h726c6400};
    run_segment(2, 1'b0, 3);
    checks++;
    if (timed_out) begin failures++; $display("FAIL hello_timeout got=1 exp=0"); end
    checks++;
    if (len_seen !== 16'd31) begin failures++; $display("FAIL hello_len_tcp got=%0d exp=31", len_seen); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL hello_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL hello_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (fin_idx != 7 || fin_cnt != 1) begin failures++; $display("FAIL hello_fin got_idx=%0d cnt=%0d exp_idx=7 cnt=1", fin_idx, fin_cnt); end
    checks++;
    if (first_dv != last_drive + 2) begin failures++; $display("FAIL hello_latency got=%0d exp=%0d", first_dv, last_drive + 2); end
  endtask

  task automatic test_too_long();
    clear_fields();
    len_data = 16'(4 * MW + 1);
    run_segment(0, 1'b0, 0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL long_timeout got=1 exp=0"); end
    checks++;
    if (err_cnt != 1 || err_cyc != 0) begin failures++; $display("FAIL long_err got_cnt=%0d cyc=%0d exp_cnt=1 cyc=0", err_cnt, err_cyc); end
    checks++;
    if (dv_cnt != 0) begin failures++; $display("FAIL long_dv got=%0d exp=0", dv_cnt); end
    checks++;
    if (busy_ever) begin failures++; $display("FAIL long_busy got=1 exp=0"); end
  endtask

  task automatic test_reset_mid_load();
    rand_fields(0);
    len_data = 16'd12;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; data_in = $urandom; data_in_valid = 1'b1;
    @(negedge clk); data_in = $urandom; data_in_valid = 1'b1;
    @(negedge clk); data_in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midload_busy got=%b exp=1", busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, data_valid, fin, err} !== 4'b0000 || data !== 32'd0 || len_tcp !== 16'd0) begin
      failures++;
      $display("FAIL midload_reset got_flags=%b data=%h len=%h exp=0", {busy, data_valid, fin, err}, data, len_tcp);
    end
    reset = 1'b0;
    clear_fields();
    run_segment(0, 1'b0, 0);
    checks++;
    if (timed_out || obs_q.size() != 5) begin
      failures++; $display("FAIL midload_after_count got=%0d exp=5", obs_q.size());
    end else begin
      checks++;
      if (obs_q[4] !== 32'hAFE50000) begin failures++; $display("FAIL midload_after_csum got=%h exp=afe50000", obs_q[4]); end
    end
  endtask

  task automatic test_ignore_during_hdr();
    logic [31:0] ref_q[$];
    rand_fields(20);
    if (len_data == 0) len_data = 16'd7;
    build_expected();
    run_segment(1, 1'b0, (int'(len_data) + 3) / 4);
    ref_q = obs_q;
    run_segment(1, 1'b1, (int'(len_data) + 3) / 4);
    checks++;
    if (timed_out || obs_q.size() != exp_q.size() || ref_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL hdr_ignore_count got=%0d ref=%0d exp=%0d", obs_q.size(), ref_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size() && i < ref_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== ref_q[i] || obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL hdr_ignore_word%0d got=%h ref=%h exp=%h", i, obs_q[i], ref_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fin_cnt != 1 || fin_idx != exp_q.size() - 1) begin
      failures++; $display("FAIL hdr_ignore_fin got_idx=%0d cnt=%0d exp_idx=%0d", fin_idx, fin_cnt, exp_q.size() - 1);
    end
  endtask

  // Random segments issued back to back: each new start is presented in the
  // cycle right after busy is first seen low.
  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      rand_fields(4 * MW);
      if (it == 0) len_data = 16'(4 * MW);
      if (it == 1) len_data = 16'd1;
      if (it == 2) len_data = 16'd4;
      build_expected();
      run_segment($urandom_range(0, 2), 1'b0, (int'(len_data) + 3) / 4);
      checks++;
      if (timed_out) begin failures++; $display("FAIL rand%0d_timeout got=1 exp=0", it); end
      checks++;
      if (len_seen !== exp_len) begin failures++; $display("FAIL rand%0d_len_tcp got=%0d exp=%0d", it, len_seen, exp_len); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_word%0d got=%h exp=%h", it, i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (fin_cnt != 1 || fin_idx != exp_q.size() - 1) begin
        failures++; $display("FAIL rand%0d_fin got_idx=%0d cnt=%0d exp_idx=%0d", it, fin_idx, fin_cnt, exp_q.size() - 1);
      end
      checks++;
      if (busy_after_fin !== 1'b0) begin failures++; $display("FAIL rand%0d_busy_drop got=%b exp=0", it, busy_after_fin); end
      checks++;
      if (first_dv != last_drive + 2) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, first_dv, last_drive + 2); end
    end
  endtask

`ifdef TCP_MSS_OPTION_EN
  task automatic test_mss();
    clear_fields();
    mss_en = 1'b1; mss = 16'h05B4;
    // ~(0x0006 + 0x0018 + 0x6000 + 0x0204 + 0x05B4) = ~0x67D6 = 0x9829
    exp_q = '{32'h0, 32'h0, 32'h0, 32'h60000000, 32'h98290000, 32'h020405B4};
    run_segment(0, 1'b0, 0);
    checks++;
    if (len_seen !== 16'h0018) begin failures++; $display("FAIL mss_len_tcp got=%h exp=0018", len_seen); end
    checks++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL mss_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL mss_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (fin_idx != 5 || fin_cnt != 1) begin failures++; $display("FAIL mss_fin got_idx=%0d cnt=%0d exp_idx=5 cnt=1", fin_idx, fin_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_len();
    test_hello();
    test_too_long();
    test_reset_mid_load();
    test_ignore_during_hdr();
    test_random();
`ifdef TCP_MSS_OPTION_EN
    test_mss();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
